// File: rtl/led_framebuffer_if.sv
`default_nettype none
// ============================================================================
// Module   : led_framebuffer_if
// Purpose  : Scan-read, pixel-write and swap signals between LED_controller /
//            pixel producer (master) and led_framebuffer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface led_framebuffer_if #(
    parameter int COLOR_DEPTH = 4,
    parameter int ROW_W       = 5,
    parameter int COL_W       = 6
) ();
    localparam int C_PLANE_W = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;

    logic [ROW_W-1:0]         row_addr;
    logic [COL_W-1:0]         col_addr;
    logic                     re;
    logic                     latch;
    logic                     wr_en;
    logic [COL_W-1:0]         wr_x;
    logic [ROW_W:0]           wr_y;
    logic [3*COLOR_DEPTH-1:0] wr_rgb;
    logic                     swap_req;
    logic [2:0]               rgb_top;
    logic [2:0]               rgb_bot;
    logic                     pix_valid;
    logic [C_PLANE_W-1:0]     plane;
    logic                     swap_done;
    logic                     front_sel;

    modport master (
        output row_addr, col_addr, re, latch, wr_en, wr_x, wr_y, wr_rgb, swap_req,
        input  rgb_top, rgb_bot, pix_valid, plane, swap_done, front_sel
    );

    modport slave (
        input  row_addr, col_addr, re, latch, wr_en, wr_x, wr_y, wr_rgb, swap_req,
        output rgb_top, rgb_bot, pix_valid, plane, swap_done, front_sel
    );
endinterface
`default_nettype wire

// File: rtl/led_framebuffer.sv
`default_nettype none
// ============================================================================
// Module   : led_framebuffer
// Purpose  : Double-buffered 64x64 HUB75 pixel store with BCM plane sequencing
//            and tear-free buffer swap at frame boundaries.
//            Optional: LED_FRAMEBUFFER_GAMMA_EN adds a gamma LUT write stage.
// Revision : 1.0 - initial release
// ============================================================================
module led_framebuffer #(
    parameter int COLOR_DEPTH = 4,
    parameter int ROW_W       = 5,
    parameter int COL_W       = 6
) (
    input  logic           clk,
    input  logic           rst,
    led_framebuffer_if.slave bus
);
    localparam int C_PLANE_W   = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
    localparam int C_PIX_W     = 3 * COLOR_DEPTH;
    localparam int C_ADDR_W    = ROW_W + COL_W;
    localparam int C_MEM_DEPTH = 2 ** (C_ADDR_W + 1);
    localparam logic [C_PLANE_W-1:0] C_LAST_PLANE = C_PLANE_W'(COLOR_DEPTH - 1);
    localparam logic [ROW_W-1:0]     C_LAST_ROW   = '1;

    // Each half is indexed {buffer, line[ROW_W-1:0], column}.
    logic [C_PIX_W-1:0] mem_top [C_MEM_DEPTH];
    logic [C_PIX_W-1:0] mem_bot [C_MEM_DEPTH];

    logic [2:0]           rgb_top_q, rgb_top_d;
    logic [2:0]           rgb_bot_q, rgb_bot_d;
    logic                 pix_valid_q, pix_valid_d;
    logic [C_PLANE_W-1:0] plane_q, plane_d;
    logic                 swap_done_q, swap_done_d;
    logic                 front_sel_q, front_sel_d;
    logic                 swap_pending_q, swap_pending_d;
    logic                 latch_prev_q, latch_prev_d;

    logic                 w_mem_we;
    logic                 w_mem_half;
    logic                 w_mem_buf;
    logic [C_ADDR_W-1:0]  w_mem_addr;
    logic [C_PIX_W-1:0]   w_mem_data;
    logic [C_ADDR_W:0]    w_rd_addr;
    logic [C_PIX_W-1:0]   w_top_word;
    logic [C_PIX_W-1:0]   w_bot_word;
    logic                 w_fb;
    logic                 w_swap_hit;

    function automatic logic [2:0] plane_bits(input logic [C_PIX_W-1:0] word,
                                              input logic [C_PLANE_W-1:0] p);
        logic [COLOR_DEPTH-1:0] r;
        logic [COLOR_DEPTH-1:0] g;
        logic [COLOR_DEPTH-1:0] b;
        r = word[C_PIX_W-1 -: COLOR_DEPTH];
        g = word[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
        b = word[COLOR_DEPTH-1:0];
        return {r[p], g[p], b[p]};
    endfunction

`ifdef LED_FRAMEBUFFER_GAMMA_EN
    localparam logic [3:0] C_GAMMA4 [16] = '{
        4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
        4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12, 4'd15
    };

    logic                wr_vld_q, wr_vld_d;
    logic                wr_buf_q, wr_buf_d;
    logic                wr_half_q, wr_half_d;
    logic [C_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [C_PIX_W-1:0]  wr_data_q, wr_data_d;
    logic                swap_defer_q, swap_defer_d;

    function automatic logic [COLOR_DEPTH-1:0] gamma_ch(input logic [COLOR_DEPTH-1:0] v);
        return C_GAMMA4[v];
    endfunction

    always_comb begin
        wr_vld_d  = bus.wr_en;
        wr_buf_d  = ~front_sel_q;
        wr_half_d = bus.wr_y[ROW_W];
        wr_addr_d = {bus.wr_y[ROW_W-1:0], bus.wr_x};
        wr_data_d = {gamma_ch(bus.wr_rgb[C_PIX_W-1 -: COLOR_DEPTH]),
                     gamma_ch(bus.wr_rgb[2*COLOR_DEPTH-1 -: COLOR_DEPTH]),
                     gamma_ch(bus.wr_rgb[COLOR_DEPTH-1:0])};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_vld_q  <= 1'b0;
            wr_buf_q  <= 1'b0;
            wr_half_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_vld_q  <= wr_vld_d;
            wr_buf_q  <= wr_buf_d;
            wr_half_q <= wr_half_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign w_mem_we   = wr_vld_q;
    assign w_mem_buf  = wr_buf_q;
    assign w_mem_half = wr_half_q;
    assign w_mem_addr = wr_addr_q;
    assign w_mem_data = wr_data_q;
`else
    assign w_mem_we   = bus.wr_en;
    assign w_mem_buf  = ~front_sel_q;
    assign w_mem_half = bus.wr_y[ROW_W];
    assign w_mem_addr = {bus.wr_y[ROW_W-1:0], bus.wr_x};
    assign w_mem_data = bus.wr_rgb;
`endif

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            if (w_mem_half) mem_bot[{w_mem_buf, w_mem_addr}] <= w_mem_data;
            else            mem_top[{w_mem_buf, w_mem_addr}] <= w_mem_data;
        end
    end

    assign w_rd_addr  = {front_sel_q, bus.row_addr, bus.col_addr};
    assign w_top_word = mem_top[w_rd_addr];
    assign w_bot_word = mem_bot[w_rd_addr];

    // Frame boundary: rising latch on the last scan row.
    assign w_fb       = bus.latch & ~latch_prev_q & (bus.row_addr == C_LAST_ROW);
    assign w_swap_hit = w_fb & (plane_q == C_LAST_PLANE) & (swap_pending_q | bus.swap_req);

    always_comb begin
        rgb_top_d      = rgb_top_q;
        rgb_bot_d      = rgb_bot_q;
        pix_valid_d    = bus.re;
        plane_d        = plane_q;
        swap_done_d    = 1'b0;
        front_sel_d    = front_sel_q;
        swap_pending_d = swap_pending_q | bus.swap_req;
        latch_prev_d   = bus.latch;

        if (bus.re) begin
            rgb_top_d = plane_bits(w_top_word, plane_q);
            rgb_bot_d = plane_bits(w_bot_word, plane_q);
        end

        if (w_fb) begin
            plane_d = (plane_q == C_LAST_PLANE) ? '0 : plane_q + 1'b1;
        end

`ifdef LED_FRAMEBUFFER_GAMMA_EN
        // A staged write must land in the old back buffer before it becomes front.
        swap_defer_d = 1'b0;
        if (w_swap_hit) begin
            swap_pending_d = 1'b0;
            if (wr_vld_q) begin
                swap_defer_d = 1'b1;
            end else begin
                front_sel_d = ~front_sel_q;
                swap_done_d = 1'b1;
            end
        end
        if (swap_defer_q) begin
            front_sel_d = ~front_sel_q;
            swap_done_d = 1'b1;
        end
`else
        if (w_swap_hit) begin
            swap_pending_d = 1'b0;
            front_sel_d    = ~front_sel_q;
            swap_done_d    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_top_q      <= '0;
            rgb_bot_q      <= '0;
            pix_valid_q    <= 1'b0;
            plane_q        <= '0;
            swap_done_q    <= 1'b0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            latch_prev_q   <= 1'b0;
`ifdef LED_FRAMEBUFFER_GAMMA_EN
            swap_defer_q   <= 1'b0;
`endif
        end else begin
            rgb_top_q      <= rgb_top_d;
            rgb_bot_q      <= rgb_bot_d;
            pix_valid_q    <= pix_valid_d;
            plane_q        <= plane_d;
            swap_done_q    <= swap_done_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            latch_prev_q   <= latch_prev_d;
`ifdef LED_FRAMEBUFFER_GAMMA_EN
            swap_defer_q   <= swap_defer_d;
`endif
        end
    end

    assign bus.rgb_top   = rgb_top_q;
    assign bus.rgb_bot   = rgb_bot_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.plane     = plane_q;
    assign bus.swap_done = swap_done_q;
    assign bus.front_sel = front_sel_q;
endmodule
`default_nettype wire

// File: tb/tb_led_framebuffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_framebuffer
// Purpose  : Directed and randomized bench for led_framebuffer against a
//            frame-level reference model (pixel arrays, plane and swap state).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_framebuffer;
    localparam int CD = 4;
    localparam int RW = 5;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_framebuffer_if #(.COLOR_DEPTH(CD), .ROW_W(RW), .COL_W(CW)) bus ();

    led_framebuffer #(.COLOR_DEPTH(CD), .ROW_W(RW), .COL_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    // Reference model: pixels per buffer/line/column (-1 = never written).
    int mem [2][64][64];
    int m_front, m_plane, m_top, m_bot;
    bit m_pend, m_prev_latch, m_valid, m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int plane_bits(input int v, input int p);
        if (v < 0) return -1;
        return (((v >> (8 + p)) & 1) << 2) | (((v >> (4 + p)) & 1) << 1) | ((v >> p) & 1);
    endfunction

    task automatic model_reset();
        m_front = 0; m_plane = 0; m_pend = 0; m_prev_latch = 0;
        m_valid = 0; m_done = 0; m_top = 0; m_bot = 0;
    endtask

    task automatic model_step();
        bit fb;
        int row, col;
        if (!rst) begin
            model_reset();
            return;
        end
        row = int'(bus.row_addr);
        col = int'(bus.col_addr);
        fb  = bus.latch && !m_prev_latch && (row == 31);
        m_valid = bus.re;
        if (bus.re) begin
            m_top = plane_bits(mem[m_front][row][col], m_plane);
            m_bot = plane_bits(mem[m_front][row + 32][col], m_plane);
        end
        if (bus.wr_en) mem[1 - m_front][int'(bus.wr_y)][int'(bus.wr_x)] = int'(bus.wr_rgb);
        m_done = 0;
        if (fb && m_plane == CD - 1 && (m_pend || bus.swap_req)) begin
            m_front = 1 - m_front;
            m_pend  = 0;
            m_done  = 1;
        end else if (bus.swap_req) begin
            m_pend = 1;
        end
        if (fb) m_plane = (m_plane + 1) % CD;
        m_prev_latch = bus.latch;
    endtask

    task automatic compare_all();
        check("pix_valid", bus.pix_valid, m_valid);
        check("plane", bus.plane, m_plane);
        check("front_sel", bus.front_sel, m_front);
        check("swap_done", bus.swap_done, m_done);
        if (m_top >= 0) check("rgb_top", bus.rgb_top, m_top);
        if (m_bot >= 0) check("rgb_bot", bus.rgb_bot, m_bot);
        if (bus.swap_done) n_done++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_fb(input bit req);
        bus.row_addr = 5'd31; bus.latch = 1'b0; tick();
        bus.latch = 1'b1; bus.swap_req = req;   tick();
        bus.latch = 1'b0; bus.swap_req = 1'b0;  tick();
    endtask

    task automatic pulse_req();
        bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    endtask

    task automatic write_px(input int x, input int y, input logic [11:0] rgb);
        bus.wr_en = 1'b1; bus.wr_x = 6'(x); bus.wr_y = 6'(y); bus.wr_rgb = rgb;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic read_px(input int row, input int col);
        bus.re = 1'b1; bus.row_addr = 5'(row); bus.col_addr = 6'(col);
        tick();
        bus.re = 1'b0;
    endtask

    int rows [5] = '{0, 1, 2, 3, 31};
    int cols [5] = '{0, 1, 5, 6, 63};

    initial begin
        for (int b = 0; b < 2; b++)
            for (int y = 0; y < 64; y++)
                for (int x = 0; x < 64; x++) mem[b][y][x] = -1;
        bus.row_addr = '0; bus.col_addr = '0; bus.re = 1'b0; bus.latch = 1'b0;
        bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0; bus.swap_req = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b1;

        // Reset mid-run with plane 2 and a pending swap.
        write_px(1, 1, 12'hFFF);
        do_fb(1'b0); do_fb(1'b0);
        pulse_req();
        read_px(1, 1);
        check("plane_before_rst", bus.plane, 2);
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_rgb_top", bus.rgb_top, 0);
        check("rst_rgb_bot", bus.rgb_bot, 0);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_plane", bus.plane, 0);
        check("rst_swap_done", bus.swap_done, 0);
        check("rst_front_sel", bus.front_sel, 0);
        tick();
        rst = 1'b1;
        n_done = 0;
        repeat (4) do_fb(1'b0);
        check("no_swap_after_rst", n_done, 0);

        // Top pixel through a requested swap.
        write_px(5, 3, 12'hF00);
        pulse_req();
        n_done = 0;
        repeat (3) do_fb(1'b0);
        check("swap_not_early", n_done, 0);
        do_fb(1'b0);
        check("swap_on_4th_fb", n_done, 1);
        check("front_after_swap", bus.front_sel, 1);
        for (int p = 0; p < CD; p++) begin
            read_px(3, 5);
            check("top_px_valid", bus.pix_valid, 1);
            check("top_px_red", bus.rgb_top, 3'b100);
            do_fb(1'b0);
        end

        // Back-buffer isolation and bottom-half pixel.
        write_px(5, 3, 12'h0F0);
        write_px(63, 35, 12'h0A5);
        read_px(3, 5);
        check("isolated_top", bus.rgb_top, 3'b100);
        pulse_req();
        repeat (4) do_fb(1'b0);
        check("front_back_to_0", bus.front_sel, 0);
        for (int p = 0; p < CD; p++) begin
            read_px(3, 5);
            check("swapped_top", bus.rgb_top, 3'b010);
            read_px(3, 63);
            check("bot_px", bus.rgb_bot, (p % 2 == 0) ? 3'b001 : 3'b010);
            do_fb(1'b0);
        end

        // No request: plane walks, nothing swaps.
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            do_fb(1'b0);
            check("plane_seq", bus.plane, (i + 1) % CD);
        end
        check("no_req_no_done", n_done, 0);
        check("no_req_front", bus.front_sel, 0);

        // Request coincident with the swap-point FB, then a doubled request.
        repeat (3) do_fb(1'b0);
        n_done = 0;
        do_fb(1'b1);
        check("coincident_swap", n_done, 1);
        check("coincident_front", bus.front_sel, 1);
        pulse_req(); tick(); pulse_req();
        n_done = 0;
        repeat (4) do_fb(1'b0);
        check("double_req_one_swap", n_done, 1);
        check("double_req_front", bus.front_sel, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.re       = ($urandom_range(0, 1) == 1);
            bus.row_addr = 5'(rows[$urandom_range(0, 4)]);
            bus.col_addr = 6'(cols[$urandom_range(0, 4)]);
            bus.latch    = ($urandom_range(0, 2) == 0);
            bus.wr_en    = ($urandom_range(0, 2) == 0);
            bus.wr_x     = 6'(cols[$urandom_range(0, 4)]);
            bus.wr_y     = 6'(rows[$urandom_range(0, 4)] + 32 * $urandom_range(0, 1));
            bus.wr_rgb   = 12'($urandom);
            bus.swap_req = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/led_framebuffer.md
Name: led_framebuffer

Overview:
- Double-buffered pixel store feeding the LED panel scan path for a 64x64 HUB75 panel with 1/32 scan.
- Sits directly downstream of LED_controller: consumes its row_addr/col_addr/re/latch and returns one top-half and one bottom-half RGB bit per read, selected by the current binary-coded-modulation bit plane.
- The pixel producer writes the back buffer; buffers swap only at a frame boundary so the panel never shows a torn frame.

Parameters:
- COLOR_DEPTH, 4, bits per colour channel; one bit plane per bit.
- ROW_W, 5, row address width (32 scan rows; bottom half = row+32).
- COL_W, 6, column address width (64 columns).

Ports:
- clk  in  1  system clock, shared with LED_controller
- rst  in  1  asynchronous, active-low reset
- row_addr  in  ROW_W  scan row from LED_controller
- col_addr  in  COL_W  column from LED_controller
- re  in  1  read enable from LED_controller
- latch  in  1  row latch from LED_controller
- wr_en  in  1  write strobe, back buffer
- wr_x  in  6  write column 0..63
- wr_y  in  6  write line 0..63
- wr_rgb  in  3*COLOR_DEPTH  packed {r,g,b}, MSB-first per channel
- swap_req  in  1  request buffer swap (pulse)
- rgb_top  out  3  {r,g,b} plane bit, pixel (col, row)
- rgb_bot  out  3  {r,g,b} plane bit, pixel (col, row+32)
- pix_valid  out  1  rgb_top/rgb_bot valid this cycle
- plane  out  clog2(COLOR_DEPTH)  current bit plane
- swap_done  out  1  one-cycle pulse when the swap takes effect
- front_sel  out  1  index of the buffer being displayed

Behaviour:
- Reset (rst=0, async): rgb_top=0, rgb_bot=0, pix_valid=0, plane=0, swap_done=0, front_sel=0, swap_pending=0. Memory contents are not reset.
- Storage: per buffer, two halves (lines 0-31 and 32-63), each 2048 x 3*COLOR_DEPTH. Both halves are read in one cycle.
- Read latency 1: re=1 sampled at edge N gives pix_valid=1 after edge N+1.
  - rgb_top = {r[plane], g[plane], b[plane]} of front[row_addr][col_addr].
  - rgb_bot is the same for line row_addr+32.
  - Address, front_sel and plane are all sampled at edge N.
- re=0: pix_valid=0 next cycle; rgb outputs hold their last value.
- Write: wr_en=1 writes wr_rgb to back buffer (~front_sel) at line wr_y, column wr_x, in one cycle. wr_y[5] selects the half. The front buffer is never writable.
- A write on the swap edge targets the buffer that was back before that edge.
- Frame boundary event (FB): latch registered 0 and now 1 (rising edge) while row_addr == 2^ROW_W-1.
- Plane FSM:
  - On FB with plane < COLOR_DEPTH-1: plane+1.
  - On FB with plane == COLOR_DEPTH-1: plane returns to 0. This is the swap point.
- Swap:
  - swap_req sets swap_pending. A swap_req while already pending is absorbed; one swap only.
  - At the swap point, if swap_pending or swap_req is high in that cycle: front_sel toggles, swap_pending clears, swap_done=1 for exactly one cycle.
  - Otherwise front_sel is unchanged and swap_done stays 0.
- Reset mid-operation discards any pending swap and restarts at plane 0 with front_sel=0.

Optional Feature:
- Macro LED_FRAMEBUFFER_GAMMA_EN.
- Defined: each wr_rgb channel passes through a COLOR_DEPTH-bit gamma LUT before storage (for COLOR_DEPTH=4: 0,0,0,1,1,2,2,3,4,5,6,7,9,10,12,15). The LUT adds one register stage, so write latency is 2 cycles.
  - A swap is deferred one cycle if a registered write is still in flight.
- Undefined: data is stored unchanged with 1-cycle write latency.

Test Plan:
- Reset: drive rst=0 mid-run with plane=2 and swap_pending=1 -> all outputs 0 immediately, plane=0, front_sel=0; after release, 4 FBs produce no swap_done.
- Top pixel: write (x=5,y=3,rgb=12'hF00), pulse swap_req, generate 4 FBs -> swap_done on the 4th, front_sel=1; re at row 3, col 5 -> next cycle pix_valid=1, rgb_top=3'b100 on all 4 planes.
- Bottom pixel: write (x=63,y=35,rgb=12'h0A5), swap, read row 3, col 63 -> rgb_bot=3'b001 on planes 0 and 2, 3'b010 on planes 1 and 3.
- Isolation: after the swap, write (5,3) with 12'h0F0 -> reads still return rgb_top=3'b100 until the next swap, then 3'b010.
- No request: 8 FBs without swap_req -> plane sequence 1,2,3,0,1,2,3,0; swap_done never 1; front_sel constant.
- Coincidence: swap_req in the same cycle as the plane-3 FB -> swap happens on that edge; a second swap_req while pending -> only one swap_done.
